// File: rtl/pll_reset_sequencer.sv
// Holds the downstream 48 MHz domain in reset until the PLL has reported lock
// continuously for STABLE_CYCLES, and keeps it there for HOLD_CYCLES after a loss.
module pll_reset_sequencer #(
    parameter int STABLE_CYCLES = 4800,
    parameter int HOLD_CYCLES   = 48,
    parameter int COUNT_W       = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       locked,
    output logic       rst_out,
    output logic       ready,
    output logic [1:0] state,
    output logic [7:0] relock_count
);

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        WAIT_STABLE = 2'd1,
        RUN         = 2'd2,
        HOLD        = 2'd3
    } state_t;

    if (STABLE_CYCLES < 1 || HOLD_CYCLES < 1 ||
        longint'(STABLE_CYCLES) >= (longint'(1) << COUNT_W) ||
        longint'(HOLD_CYCLES) >= (longint'(1) << COUNT_W)) begin : g_bad_params
        $error("pll_reset_sequencer: STABLE_CYCLES/HOLD_CYCLES must be in [1, 2**COUNT_W)");
    end

    localparam logic [COUNT_W-1:0] STABLE_LAST = COUNT_W'(STABLE_CYCLES - 1);
    localparam logic [COUNT_W-1:0] HOLD_LAST   = COUNT_W'(HOLD_CYCLES - 1);

    state_t             cur;
    state_t             nxt;
    logic [COUNT_W-1:0] count;
    logic [COUNT_W-1:0] count_nxt;
    logic               sync1;
    logic               lock_s;
    logic [7:0]         relocks;
    logic               relock_inc;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1   <= 1'b0;
            lock_s  <= 1'b0;
            cur     <= IDLE;
            count   <= '0;
            relocks <= '0;
        end else begin
            sync1  <= locked;
            lock_s <= sync1;
            cur    <= nxt;
            count  <= count_nxt;
            // Saturates so a flapping PLL can never make the count look healthy again.
            if (relock_inc && relocks != 8'hFF) begin
                relocks <= relocks + 8'd1;
            end
        end
    end

    always_comb begin
        nxt        = cur;
        count_nxt  = count;
        relock_inc = 1'b0;
        case (cur)
            IDLE: begin
                count_nxt = '0;
                if (lock_s) begin
                    nxt = WAIT_STABLE;
                end
            end
            WAIT_STABLE: begin
                if (!lock_s) begin
                    nxt       = IDLE;
                    count_nxt = '0;
                end else if (count == STABLE_LAST) begin
                    nxt       = RUN;
                    count_nxt = '0;
                end else begin
                    count_nxt = count + 1'b1;
                end
            end
            RUN: begin
                count_nxt = '0;
                if (!lock_s) begin
                    nxt        = HOLD;
                    relock_inc = 1'b1;
                end
            end
            HOLD: begin
                // Lock is deliberately ignored here so the hold time is a hard minimum.
                if (count == HOLD_LAST) begin
                    nxt       = IDLE;
                    count_nxt = '0;
                end else begin
                    count_nxt = count + 1'b1;
                end
            end
        endcase
    end

    assign rst_out      = (cur != RUN);
    assign ready        = (cur == RUN);
    assign state        = cur;
    assign relock_count = relocks;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Bench for pll_reset_sequencer: directed scenarios plus randomized lock activity,
// each cycle compared with a behavioural model of the lock qualification rules.
module tb_pll_reset_sequencer;

    localparam int S = 8;
    localparam int H = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       locked = 1'b0;
    logic       rst_out;
    logic       ready;
    logic [1:0] state;
    logic [7:0] relock_count;

    int total = 0;
    int bad = 0;

    pll_reset_sequencer #(
        .STABLE_CYCLES(S),
        .HOLD_CYCLES  (H),
        .COUNT_W      (16)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .locked      (locked),
        .rst_out     (rst_out),
        .ready       (ready),
        .state       (state),
        .relock_count(relock_count)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit expired, actual=running required=finished");
        $fatal(1, "watchdog");
    end

    wire logic [11:0] dut_vec = {rst_out, ready, state, relock_count};

    // Model: lock history seen by the sequencer lags the pin by two edges.
    int   m_mode = 0;      // 0 idle, 1 qualifying, 2 released, 3 holding
    int   m_streak = 0;    // qualifying cycles completed
    int   m_held = 0;      // hold cycles completed
    int   m_relocks = 0;
    logic m_q0 = 1'b0;
    logic m_q1 = 1'b0;

    function automatic logic [11:0] model_vec();
        return {m_mode != 2, m_mode == 2, 2'(m_mode), 8'(m_relocks)};
    endfunction

    task automatic model_edge();
        logic ls;
        if (reset) begin
            m_mode = 0; m_streak = 0; m_held = 0; m_relocks = 0;
            m_q0 = 1'b0; m_q1 = 1'b0;
        end else begin
            ls = m_q0;
            m_q0 = m_q1;
            m_q1 = locked;
            case (m_mode)
                0: if (ls) begin m_mode = 1; m_streak = 0; end
                1: begin
                    if (!ls) m_mode = 0;
                    else if (m_streak == S - 1) m_mode = 2;
                    else m_streak = m_streak + 1;
                end
                2: if (!ls) begin
                    m_mode = 3; m_held = 0;
                    m_relocks = (m_relocks < 255) ? m_relocks + 1 : 255;
                end
                default: begin
                    if (m_held == H - 1) m_mode = 0;
                    else m_held = m_held + 1;
                end
            endcase
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic wait_ready(input int budget, output int edges);
        edges = 0;
        while (!ready && edges < budget) begin
            tick();
            edges++;
        end
    endtask

    task automatic test_reset();
        locked = 1'($urandom_range(0, 1));
        reset = 1'b1;
        tick();
        total++;
        if (dut_vec !== 12'b1_0_00_00000000) begin
            bad++;
            $display("FAIL reset_outputs actual=%h required=%h", dut_vec, 12'b1_0_00_00000000);
        end
        total++;
        if (dut.count !== 16'd0) begin
            bad++;
            $display("FAIL reset_counter actual=%0d required=0", dut.count);
        end
        tick();
        reset = 1'b0;
    endtask

    task automatic test_qualify();
        do_reset();
        locked = 1'b1;
        for (int e = 1; e <= S + 6; e++) begin
            tick();
            total++;
            if (ready !== (e >= S + 3) || rst_out !== (e < S + 3)) begin
                bad++;
                $display("FAIL qualify_edge%0d actual ready=%b rst_out=%b required ready=%b", e, ready, rst_out, e >= S + 3);
            end
            total++;
            if (dut_vec !== model_vec()) begin
                bad++;
                $display("FAIL qualify_model actual=%h required=%h", dut_vec, model_vec());
            end
        end
        total++;
        if (dut_vec !== 12'b0_1_10_00000000) begin
            bad++;
            $display("FAIL qualify_run actual=%h required=%h", dut_vec, 12'b0_1_10_00000000);
        end
    endtask

    task automatic test_lock_loss();
        int n;
        int edges;
        locked = 1'b0;
        tick();
        locked = 1'b1;
        tick();
        total++;
        if (state !== 2'd2) begin
            bad++;
            $display("FAIL loss_edge2 actual state=%0d required=2", state);
        end
        tick();
        total++;
        if (dut_vec !== 12'b1_0_11_00000001) begin
            bad++;
            $display("FAIL loss_edge3 actual=%h required=%h", dut_vec, 12'b1_0_11_00000001);
        end
        n = 1;
        while (state == 2'd3 && n < 20) begin
            tick();
            if (state == 2'd3) n++;
        end
        total++;
        if (n !== H || state !== 2'd0) begin
            bad++;
            $display("FAIL hold_length actual=%0d state=%0d required=%0d state=0", n, state, H);
        end
        wait_ready(40, edges);
        total++;
        if (ready !== 1'b1 || relock_count !== 8'd1 || dut_vec !== model_vec()) begin
            bad++;
            $display("FAIL requalify actual=%h required=%h", dut_vec, model_vec());
        end
    endtask

    task automatic test_glitch();
        int edges;
        bit saw_idle;
        do_reset();
        locked = 1'b1;
        repeat (5) tick();
        locked = 1'b0;
        saw_idle = 1'b0;
        repeat (3) begin
            tick();
            if (state == 2'd0) saw_idle = 1'b1;
        end
        total++;
        if (!saw_idle) begin
            bad++;
            $display("FAIL glitch_abort actual state=%0d required=0", state);
        end
        locked = 1'b1;
        wait_ready(40, edges);
        total++;
        if (edges !== S + 3 || ready !== 1'b1) begin
            bad++;
            $display("FAIL glitch_latency actual=%0d required=%0d", edges, S + 3);
        end
        total++;
        if (dut_vec !== model_vec()) begin
            bad++;
            $display("FAIL glitch_model actual=%h required=%h", dut_vec, model_vec());
        end
    endtask

    task automatic test_reset_mid();
        int n;
        int edges;
        do_reset();
        locked = 1'b1;
        n = 0;
        while (!(state == 2'd1 && dut.count == 16'd5) && n < 20) begin
            tick();
            n++;
        end
        total++;
        if (state !== 2'd1 || dut.count !== 16'd5) begin
            bad++;
            $display("FAIL mid_wait_reach actual state=%0d count=%0d required state=1 count=5", state, dut.count);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        total++;
        if (dut_vec !== 12'b1_0_00_00000000 || dut.count !== 16'd0) begin
            bad++;
            $display("FAIL mid_wait_reset actual=%h count=%0d required=%h count=0", dut_vec, dut.count, 12'b1_0_00_00000000);
        end
        wait_ready(40, edges);
        total++;
        if (edges !== S + 3) begin
            bad++;
            $display("FAIL mid_wait_requalify actual=%0d required=%0d", edges, S + 3);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        total++;
        if (dut_vec !== 12'b1_0_00_00000000 || dut.count !== 16'd0) begin
            bad++;
            $display("FAIL mid_run_reset actual=%h count=%0d required=%h count=0", dut_vec, dut.count, 12'b1_0_00_00000000);
        end
    endtask

    task automatic test_saturate();
        int edges;
        int want;
        do_reset();
        locked = 1'b1;
        wait_ready(40, edges);
        for (int k = 1; k <= 260; k++) begin
            locked = 1'b0;
            tick();
            locked = 1'b1;
            tick();
            tick();
            wait_ready(40, edges);
            want = (k < 255) ? k : 255;
            total++;
            if (ready !== 1'b1 || relock_count !== 8'(want)) begin
                bad++;
                $display("FAIL saturate_k%0d actual ready=%b count=%0d required ready=1 count=%0d", k, ready, relock_count, want);
            end
            total++;
            if (dut_vec !== model_vec()) begin
                bad++;
                $display("FAIL saturate_model actual=%h required=%h", dut_vec, model_vec());
            end
        end
    endtask

    task automatic test_idle_long();
        do_reset();
        locked = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            tick();
            total++;
            if (dut_vec !== 12'b1_0_00_00000000) begin
                bad++;
                $display("FAIL idle_cycle%0d actual=%h required=%h", i, dut_vec, 12'b1_0_00_00000000);
            end
        end
    endtask

    task automatic test_random();
        int len;
        do_reset();
        for (int seg = 0; seg < 250; seg++) begin
            locked = 1'($urandom_range(0, 1));
            len = ($urandom_range(0, 3) == 0) ? $urandom_range(S + 4, 30) : $urandom_range(1, 6);
            for (int c = 0; c < len; c++) begin
                reset = ($urandom_range(0, 199) == 0);
                tick();
                total++;
                if (dut_vec !== model_vec()) begin
                    bad++;
                    $display("FAIL random_seg%0d actual=%h required=%h", seg, dut_vec, model_vec());
                end
            end
        end
        reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_qualify();
        test_lock_loss();
        test_glitch();
        test_reset_mid();
        test_saturate();
        test_idle_long();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
